dcache_flush_seq: RTL and testbench
===================================

Name: dcache_flush_seq

Overview:
- Write-back DCache flush sequencer; sits directly downstream of the flush controller.
- Consumes the registered level flush request and walks every set of the write-back DCache.
- Writes back all valid+dirty ways, then invalidates each set.
- Returns a one-cycle acknowledge that clears the controller's active-fence state and releases the commit halt.

Parameters:
NUM_SETS, 256, sets in cache; power of two, >=2; IDX_W = log2(NUM_SETS)
NUM_WAYS, 8, ways per set; power of two, >=2; WAY_W = log2(NUM_WAYS)
PLEN, 56, physical address width
LINE_OFF_W, 4, byte-offset bits per line; TAG_W = PLEN-IDX_W-LINE_OFF_W (derived localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  flush request level from controller, held until ack
flush_ack_o  out  1  one-cycle pulse: entire cache clean and invalid
busy_o  out  1  high from request acceptance until ack cycle inclusive; miss unit stops accepting new misses
miss_idle_i  in  1  miss unit has no outstanding refill/writeback
tag_req_o  out  1  tag-array read request
tag_gnt_i  in  1  tag-array read grant
tag_idx_o  out  IDX_W  set index (read and invalidate)
tag_rdata_i  in  NUM_WAYS*TAG_W  tags; valid the cycle after gnt
valid_i  in  NUM_WAYS  valid bits; valid the cycle after gnt
dirty_i  in  NUM_WAYS  dirty bits; valid the cycle after gnt
wb_req_o  out  1  line writeback request
wb_gnt_i  in  1  writeback accepted
wb_addr_o  out  PLEN  {tag, idx, LINE_OFF_W'0}
wb_way_o  out  WAY_W  way being written back
wb_done_i  in  1  writeback completed at memory; earliest cycle after gnt
inval_req_o  out  1  clear valid/dirty of all ways of tag_idx_o
inval_gnt_i  in  1  invalidate write accepted

Behaviour:
- Reset: every output is 0; index reg = 0; pending mask = 0; state = IDLE. Reset mid-walk aborts with no ack; partially flushed sets remain as-is.
- IDLE: flush_i=1 -> WAIT_IDLE, busy_o=1 from the next cycle.
- WAIT_IDLE: stay until miss_idle_i=1, then -> READ.
- READ: tag_req_o=1 with tag_idx_o=idx, held stable until tag_gnt_i. On gnt -> CAPTURE.
- CAPTURE (1 cycle): pending <= valid_i & dirty_i; latch tags. Pending==0 -> INVAL, else -> WB_REQ.
- WB_REQ:
  - way = lowest set bit of pending.
  - wb_req_o=1; addr and way stay stable until wb_gnt_i. On gnt -> WB_WAIT.
  - Only one writeback is outstanding at a time.
- WB_WAIT: on wb_done_i, clear the pending bit for that way. Pending still nonzero -> WB_REQ, else -> INVAL. wb_done_i is ignored in every other state.
- INVAL: inval_req_o=1 held until inval_gnt_i. On gnt: idx==NUM_SETS-1 -> DONE; else idx+1 and -> READ.
- DONE: flush_ack_o=1 for exactly one cycle; idx cleared to 0; -> IDLE.
- IDLE does not sample flush_i in the ack cycle. The controller's registered request drops the cycle after ack, so no re-trigger occurs. A request still high two cycles after ack starts a new walk.
- flush_i deasserted mid-walk: ignored; the walk completes and acks.
- Index arithmetic is IDX_W wide. Wrap is never reached, because DONE is taken at NUM_SETS-1.
- Latency for a clean cache with zero-wait grants: 1 + 1 + NUM_SETS*3 + 1 cycles from acceptance to ack, with miss_idle_i already high.

Decomposition:
- Shared package (ariane_pkg / dcache package): NUM_SETS/NUM_WAYS/LINE_OFF_W constants, derived IDX_W/WAY_W/TAG_W, and the flush_state_e enum {IDLE, WAIT_IDLE, READ, CAPTURE, WB_REQ, WB_WAIT, INVAL, DONE}.
- Way selection uses the existing common-cells lzc (trailing-zero mode) instance.
- No other sub-module.

Test Plan:
- Bench uses NUM_SETS=4, NUM_WAYS=2, zero-wait grants, all clean -> flush_ack_o pulses at cycle 15 after flush_i rises; 0 wb_req_o; 4 inval_req_o with idx 0,1,2,3.
- Set 2, ways 0 and 1 dirty, tags 0x1A and 0x2B -> two writebacks in order: way 0 addr {0x1A,2'd2,4'h0}, then way 1 addr {0x2B,2'd2,4'h0}. Second wb_req_o only after the first wb_done_i.
- miss_idle_i low for 10 cycles after request -> no tag_req_o until it rises; busy_o high throughout.
- Backpressure: wb_gnt_i withheld 5 cycles -> wb_req_o/addr/way stable all 5 cycles. Same check for tag_gnt_i and inval_gnt_i.
- rst_i asserted in WB_WAIT -> next cycle all outputs 0, no ack. A fresh flush_i walks from idx 0.
- flush_i held high 1 cycle past ack (controller timing) -> exactly one walk, one ack pulse.

Source files
------------

// File: rtl/dcache_flush_seq_pkg.sv
// Shared constants and state encoding for the DCache flush sequencer.
package dcache_flush_seq_pkg;

    // Default cache geometry; the sequencer and its interface take these as parameter defaults.
    localparam int unsigned DEF_NUM_SETS   = 256;
    localparam int unsigned DEF_NUM_WAYS   = 8;
    localparam int unsigned DEF_PLEN       = 56;
    localparam int unsigned DEF_LINE_OFF_W = 4;

    // Walk states; explicit encodings so the raw 3-bit constants in the top stay in step.
    typedef enum logic [2:0] {
        FS_IDLE      = 3'd0,
        FS_WAIT_IDLE = 3'd1,
        FS_READ      = 3'd2,
        FS_CAPTURE   = 3'd3,
        FS_WB_REQ    = 3'd4,
        FS_WB_WAIT   = 3'd5,
        FS_INVAL     = 3'd6,
        FS_DONE      = 3'd7
    } flush_state_e;

    // Tag width left over once set index and line offset are taken out of the address.
    function automatic int unsigned calc_tag_w(input int unsigned plen,
                                               input int unsigned num_sets,
                                               input int unsigned line_off_w);
        return plen - $clog2(num_sets) - line_off_w;
    endfunction

endpackage

// File: rtl/dcache_flush_seq_if.sv
// Handshake bundle between the flush sequencer and controller / tag array / writeback / miss unit.
interface dcache_flush_seq_if
    import dcache_flush_seq_pkg::*;
#(
    parameter int unsigned NUM_SETS   = DEF_NUM_SETS,
    parameter int unsigned NUM_WAYS   = DEF_NUM_WAYS,
    parameter int unsigned PLEN       = DEF_PLEN,
    parameter int unsigned LINE_OFF_W = DEF_LINE_OFF_W
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);
    localparam int unsigned TAG_W = calc_tag_w(PLEN, NUM_SETS, LINE_OFF_W);

    logic                      flush_i;
    logic                      flush_ack_o;
    logic                      busy_o;
    logic                      miss_idle_i;
    logic                      tag_req_o;
    logic                      tag_gnt_i;
    logic [IDX_W-1:0]          tag_idx_o;
    logic [NUM_WAYS*TAG_W-1:0] tag_rdata_i;
    logic [NUM_WAYS-1:0]       valid_i;
    logic [NUM_WAYS-1:0]       dirty_i;
    logic                      wb_req_o;
    logic                      wb_gnt_i;
    logic [PLEN-1:0]           wb_addr_o;
    logic [WAY_W-1:0]          wb_way_o;
    logic                      wb_done_i;
    logic                      inval_req_o;
    logic                      inval_gnt_i;

    // Sequencer side.
    modport master (
        input  flush_i, miss_idle_i, tag_gnt_i, tag_rdata_i, valid_i, dirty_i,
               wb_gnt_i, wb_done_i, inval_gnt_i,
        output flush_ack_o, busy_o, tag_req_o, tag_idx_o, wb_req_o, wb_addr_o,
               wb_way_o, inval_req_o
    );

    // Controller / cache / miss-unit side.
    modport slave (
        output flush_i, miss_idle_i, tag_gnt_i, tag_rdata_i, valid_i, dirty_i,
               wb_gnt_i, wb_done_i, inval_gnt_i,
        input  flush_ack_o, busy_o, tag_req_o, tag_idx_o, wb_req_o, wb_addr_o,
               wb_way_o, inval_req_o
    );

endinterface

// File: rtl/dcache_flush_seq_lzc.sv
// Trailing-zero counter: index of the lowest set bit (0 when the input is all zeros).
module dcache_flush_seq_lzc #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) cnt_o = CNT_W'(i);
        end
    end

endmodule

// File: rtl/dcache_flush_seq.sv
// Write-back DCache flush sequencer: walks every set, writes back valid+dirty
// ways one at a time, invalidates the set, and acks once the last set is done.
module dcache_flush_seq
    import dcache_flush_seq_pkg::*;
#(
    parameter int unsigned NUM_SETS   = DEF_NUM_SETS,
    parameter int unsigned NUM_WAYS   = DEF_NUM_WAYS,
    parameter int unsigned PLEN       = DEF_PLEN,
    parameter int unsigned LINE_OFF_W = DEF_LINE_OFF_W
) (
    input logic                clk_i,
    input logic                rst_i,
    dcache_flush_seq_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);
    localparam int unsigned TAG_W = calc_tag_w(PLEN, NUM_SETS, LINE_OFF_W);

    localparam logic [2:0] ST_IDLE      = 3'(FS_IDLE);
    localparam logic [2:0] ST_WAIT_IDLE = 3'(FS_WAIT_IDLE);
    localparam logic [2:0] ST_READ      = 3'(FS_READ);
    localparam logic [2:0] ST_CAPTURE   = 3'(FS_CAPTURE);
    localparam logic [2:0] ST_WB_REQ    = 3'(FS_WB_REQ);
    localparam logic [2:0] ST_WB_WAIT   = 3'(FS_WB_WAIT);
    localparam logic [2:0] ST_INVAL     = 3'(FS_INVAL);
    localparam logic [2:0] ST_DONE      = 3'(FS_DONE);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

    logic [2:0]                     state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_WAYS-1:0]            pend_q, pend_d;
    logic [NUM_WAYS-1:0][TAG_W-1:0] tags_q, tags_d;

    logic [WAY_W-1:0]    way;
    logic [NUM_WAYS-1:0] way_oh;
    logic [NUM_WAYS-1:0] cap_mask;
    logic                wb_active;

    // Lowest pending way is the next one to write back; pending is stable
    // across WB_REQ/WB_WAIT so the way (and address) cannot move under a request.
    dcache_flush_seq_lzc #(.WIDTH(NUM_WAYS)) i_lzc (
        .in_i  (pend_q),
        .cnt_o (way)
    );

    assign way_oh    = NUM_WAYS'(1) << way;
    assign cap_mask  = bus.valid_i & bus.dirty_i;
    assign wb_active = (state_q == ST_WB_REQ) || (state_q == ST_WB_WAIT);

    // Output decode: handshake requests follow the state; address/way are zero outside a writeback.
    always_comb begin
        bus.busy_o      = (state_q != ST_IDLE);
        bus.flush_ack_o = (state_q == ST_DONE);
        bus.tag_req_o   = (state_q == ST_READ);
        bus.wb_req_o    = (state_q == ST_WB_REQ);
        bus.inval_req_o = (state_q == ST_INVAL);
        bus.tag_idx_o   = idx_q;
        bus.wb_way_o    = '0;
        bus.wb_addr_o   = '0;
        if (wb_active) begin
            bus.wb_way_o  = way;
            bus.wb_addr_o = {tags_q[way], idx_q, {LINE_OFF_W{1'b0}}};
        end
    end

    // Walk FSM: next state, set index, pending-writeback mask and latched tags.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        tags_d  = tags_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush_i) state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (bus.miss_idle_i) state_d = ST_READ;
            end
            ST_READ: begin
                if (bus.tag_gnt_i) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                pend_d  = cap_mask;
                tags_d  = bus.tag_rdata_i;
                state_d = (cap_mask == '0) ? ST_INVAL : ST_WB_REQ;
            end
            ST_WB_REQ: begin
                if (bus.wb_gnt_i) state_d = ST_WB_WAIT;
            end
            ST_WB_WAIT: begin
                if (bus.wb_done_i) begin
                    pend_d  = pend_q & ~way_oh;
                    state_d = ((pend_q & ~way_oh) == '0) ? ST_INVAL : ST_WB_REQ;
                end
            end
            ST_INVAL: begin
                if (bus.inval_gnt_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                // flush_i is not looked at here; the controller drops it after seeing the ack.
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any walk in progress without an ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            tags_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            tags_q  <= tags_d;
        end
    end

endmodule

// File: tb/tb_dcache_flush_seq.sv
// Directed bench for dcache_flush_seq on a 4-set, 2-way, 14-bit-address cache.
module tb_dcache_flush_seq;

    localparam int unsigned NS = 4;
    localparam int unsigned NW = 2;
    localparam int unsigned PL = 14;
    localparam int unsigned LO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int checks   = 0;
    int failures = 0;

    // Grant / completion enables controlled by the directed steps.
    logic tag_gnt_en   = 1'b1;
    logic wb_gnt_en    = 1'b1;
    logic inval_gnt_en = 1'b1;
    logic done_en      = 1'b1;
    logic done_r       = 1'b0;

    // Cache contents seen by the tag read port.
    logic [7:0] mtag   [NS][NW];
    logic [1:0] mvalid [NS];
    logic [1:0] mdirty [NS];

    // Event logs filled by the monitor.
    logic [PL-1:0] wb_addr_log [$];
    int            wb_way_log  [$];
    int            wb_cyc_log  [$];
    int            done_cyc_log[$];
    int            inv_idx_log [$];
    int            ack_cnt = 0;

    dcache_flush_seq_if #(.NUM_SETS(NS), .NUM_WAYS(NW), .PLEN(PL), .LINE_OFF_W(LO)) dif ();

    dcache_flush_seq #(.NUM_SETS(NS), .NUM_WAYS(NW), .PLEN(PL), .LINE_OFF_W(LO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign dif.tag_gnt_i   = dif.tag_req_o & tag_gnt_en;
    assign dif.wb_gnt_i    = dif.wb_req_o & wb_gnt_en;
    assign dif.inval_gnt_i = dif.inval_req_o & inval_gnt_en;
    assign dif.wb_done_i   = done_r & done_en;

    // Tag array returns data the cycle after grant; writeback completes the cycle after grant.
    always @(posedge clk) begin
        if (dif.tag_req_o && dif.tag_gnt_i) begin
            dif.tag_rdata_i <= {mtag[dif.tag_idx_o][1], mtag[dif.tag_idx_o][0]};
            dif.valid_i     <= mvalid[dif.tag_idx_o];
            dif.dirty_i     <= mdirty[dif.tag_idx_o];
        end
        done_r <= dif.wb_req_o && dif.wb_gnt_i;
    end

    always @(negedge clk) begin
        if (dif.wb_req_o && dif.wb_gnt_i) begin
            wb_addr_log.push_back(dif.wb_addr_o);
            wb_way_log.push_back(int'(dif.wb_way_o));
            wb_cyc_log.push_back(cyc);
        end
        if (dif.wb_done_i) done_cyc_log.push_back(cyc);
        if (dif.inval_req_o && dif.inval_gnt_i) inv_idx_log.push_back(int'(dif.tag_idx_o));
        if (dif.flush_ack_o) ack_cnt++;
    end

    function automatic logic [31:0] outs();
        return 32'({dif.flush_ack_o, dif.busy_o, dif.tag_req_o, dif.tag_idx_o, dif.wb_req_o,
                    dif.wb_addr_o, dif.wb_way_o, dif.inval_req_o});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int s = 0; s < int'(NS); s++) begin
            mvalid[s] = 2'b00;
            mdirty[s] = 2'b00;
            mtag[s][0] = 8'h00;
            mtag[s][1] = 8'h00;
        end
    endtask

    // Wait (bounded) at negedges for: 0 tag_req, 1 inval_req, 2 wb_req, 3 wb handshake, 4 ack.
    task automatic wait_for(input int which, output bit ok);
        int n;
        bit hit;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            case (which)
                0:       hit = dif.tag_req_o;
                1:       hit = dif.inval_req_o;
                2:       hit = dif.wb_req_o;
                3:       hit = dif.wb_req_o && dif.wb_gnt_i;
                default: hit = dif.flush_ack_o;
            endcase
            ok = hit;
            n++;
        end
    endtask

    // Raise flush, wait for ack, keep flush high one extra cycle like the registered controller does.
    task automatic run_flush(output int lat, output bit ok, output logic ack_next);
        int start;
        flush_in(1'b1);
        start = cyc;
        wait_for(4, ok);
        lat = cyc - start + 1;
        @(negedge clk);
        ack_next = dif.flush_ack_o;
        flush_in(1'b0);
    endtask

    task automatic flush_in(input logic v);
        dif.flush_i = v;
    endtask

    initial begin
        int       lat;
        bit       ok;
        logic     ack_next;
        int       base_wb, base_inv, base_done, base_ack, bad;
        logic [31:0] saved;

        dif.flush_i     = 1'b0;
        dif.miss_idle_i = 1'b1;
        clear_mem();

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs(), 32'h0);

        // Clean cache, zero-wait grants: ack in the 15th cycle counting the request cycle.
        base_wb = wb_addr_log.size(); base_inv = inv_idx_log.size(); base_ack = ack_cnt;
        run_flush(lat, ok, ack_next);
        chk("clean_ack_seen", 32'(ok), 32'h1);
        chk("clean_latency", 32'(lat), 32'd15);
        chk("ack_one_cycle", 32'(ack_next), 32'h0);
        chk("clean_no_wb", 32'(wb_addr_log.size() - base_wb), 32'd0);
        chk("clean_inval_cnt", 32'(inv_idx_log.size() - base_inv), 32'd4);
        for (int s = 0; s < 4; s++) chk("clean_inval_idx", 32'(inv_idx_log[base_inv + s]), 32'(s));
        repeat (20) @(negedge clk);
        chk("single_ack", 32'(ack_cnt - base_ack), 32'd1);
        chk("idle_after_ack", 32'(dif.busy_o), 32'h0);

        // Set 2 both ways dirty (tags 1A, 2B); set 1 valid but clean.
        clear_mem();
        mvalid[2] = 2'b11; mdirty[2] = 2'b11; mtag[2][0] = 8'h1A; mtag[2][1] = 8'h2B;
        mvalid[1] = 2'b01; mdirty[1] = 2'b00; mtag[1][0] = 8'h55;
        base_wb = wb_addr_log.size(); base_done = done_cyc_log.size();
        run_flush(lat, ok, ack_next);
        chk("dirty_ack_seen", 32'(ok), 32'h1);
        chk("dirty_latency", 32'(lat), 32'd19);
        chk("dirty_wb_cnt", 32'(wb_addr_log.size() - base_wb), 32'd2);
        chk("wb0_addr", 32'(wb_addr_log[base_wb]), 32'h6A0);      // {1A,2,0}
        chk("wb0_way", 32'(wb_way_log[base_wb]), 32'd0);
        chk("wb1_addr", 32'(wb_addr_log[base_wb + 1]), 32'hAE0);  // {2B,2,0}
        chk("wb1_way", 32'(wb_way_log[base_wb + 1]), 32'd1);
        chk("wb1_after_done", 32'(wb_cyc_log[base_wb + 1] > done_cyc_log[base_done]), 32'h1);
        repeat (3) @(negedge clk);

        // Miss unit busy for 10 cycles after the request.
        clear_mem();
        dif.miss_idle_i = 1'b0;
        flush_in(1'b1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dif.tag_req_o || !dif.busy_o) bad++;
        end
        chk("miss_wait_hold", 32'(bad), 32'd0);
        dif.miss_idle_i = 1'b1;
        @(negedge clk);
        chk("miss_release_tag_req", 32'(dif.tag_req_o), 32'h1);
        wait_for(4, ok);
        chk("miss_ack_seen", 32'(ok), 32'h1);
        @(negedge clk);
        flush_in(1'b0);
        repeat (3) @(negedge clk);

        // Backpressure on every handshake; set 2 way 1 dirty, tag 33.
        clear_mem();
        mvalid[2] = 2'b10; mdirty[2] = 2'b10; mtag[2][1] = 8'h33;
        tag_gnt_en = 1'b0; inval_gnt_en = 1'b0; wb_gnt_en = 1'b0;
        flush_in(1'b1);
        wait_for(0, ok);
        chk("tag_req_seen", 32'(ok), 32'h1);
        saved = 32'(dif.tag_idx_o);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!dif.tag_req_o || 32'(dif.tag_idx_o) != saved) bad++;
        end
        chk("tag_req_stable", 32'(bad), 32'd0);
        tag_gnt_en = 1'b1;
        wait_for(1, ok);
        chk("inval_req_seen", 32'(ok), 32'h1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!dif.inval_req_o || dif.tag_idx_o != 2'd0) bad++;
        end
        chk("inval_req_stable", 32'(bad), 32'd0);
        inval_gnt_en = 1'b1;
        wait_for(2, ok);
        chk("wb_req_seen", 32'(ok), 32'h1);
        chk("bp_wb_addr", 32'(dif.wb_addr_o), 32'hCE0);            // {33,2,0}
        chk("bp_wb_way", 32'(dif.wb_way_o), 32'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!dif.wb_req_o || dif.wb_addr_o != 14'hCE0 || dif.wb_way_o != 1'b1) bad++;
        end
        chk("wb_req_stable", 32'(bad), 32'd0);
        wb_gnt_en = 1'b1;
        wait_for(4, ok);
        chk("bp_ack_seen", 32'(ok), 32'h1);
        @(negedge clk);
        flush_in(1'b0);
        repeat (3) @(negedge clk);

        // Reset while waiting for writeback completion; set 1 way 0 dirty, tag 44.
        clear_mem();
        mvalid[1] = 2'b01; mdirty[1] = 2'b01; mtag[1][0] = 8'h44;
        done_en  = 1'b0;
        base_ack = ack_cnt;
        flush_in(1'b1);
        wait_for(3, ok);
        chk("rst_wb_hs_seen", 32'(ok), 32'h1);
        @(negedge clk);
        chk("in_wb_wait", 32'({dif.busy_o, dif.wb_req_o, dif.inval_req_o}), 32'b100);
        rst = 1'b1;
        flush_in(1'b0);
        @(negedge clk);
        chk("rst_mid_outs", outs(), 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        done_en = 1'b1;
        @(negedge clk);
        chk("rst_no_ack", 32'(ack_cnt - base_ack), 32'd0);
        base_wb = wb_addr_log.size(); base_inv = inv_idx_log.size();
        run_flush(lat, ok, ack_next);
        chk("rewalk_ack_seen", 32'(ok), 32'h1);
        chk("rewalk_latency", 32'(lat), 32'd17);
        chk("rewalk_first_idx", 32'(inv_idx_log[base_inv]), 32'd0);
        chk("rewalk_inval_cnt", 32'(inv_idx_log.size() - base_inv), 32'd4);
        chk("rewalk_wb_addr", 32'(wb_addr_log[base_wb]), 32'h1110); // {44,1,0}
        repeat (20) @(negedge clk);
        chk("rewalk_single_ack", 32'(ack_cnt - base_ack), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
